rgmii_link_speed_ctrl: RTL and testbench
========================================

// Module: rgmii_link_speed_ctrl
// PURPOSE
//  Link/speed sequencer for the RGMII PHY interface. Qualifies PHY in-band status (or forced config),
//  and drives the interface's speed select and reset. Every speed/duplex change is applied safely:
//  drain MAC TX, hold the interface in reset, switch speed, release. Sits between CSR block, RX status
//  capture (already synchronised into clk) and rgmii_phy_if.
// PARAMETERS
//  STABLE_CYCLES  8     consecutive cycles a new status must hold before acceptance (>=1)
//  IFG_CYCLES     12    consecutive idle (mac_tx_busy=0) cycles that count as drained (>=1)
//  DRAIN_TIMEOUT  4096  max cycles in DRAIN before forcing switch (> IFG_CYCLES)
//  RST_CYCLES     4     cycles if_rst is held during a switch (>=1)
// PORTS
//  clk           in   1  system clock (same clk as rgmii_phy_if)
//  rst           in   1  asynchronous, active-high reset
//  cfg_auto      in   1  1: use in-band status; 0: use cfg_speed/cfg_duplex, link forced up
//  cfg_speed     in   2  forced speed, 00=10M 01=100M 10=1G (11 reserved)
//  cfg_duplex    in   1  forced duplex, 1=full
//  ib_valid      in   1  in-band status sample valid this cycle (inter-frame only)
//  ib_link       in   1  in-band link status
//  ib_speed      in   2  in-band speed, same encoding
//  ib_duplex     in   1  in-band duplex
//  mac_tx_busy   in   1  MAC transmitting (gmii_tx_en level)
//  speed         out  2  speed select to rgmii_phy_if
//  duplex        out  1  applied duplex
//  link_up       out  1  link qualified and interface running
//  if_rst        out  1  reset to rgmii_phy_if / MAC TX
//  change_pulse  out  1  one-cycle pulse when a new status is applied (link_up rising or speed change)
//  state_o       out  3  current FSM state (debug/CSR)
// BEHAVIOUR
//  - Reset values: speed=2'b10, duplex=1, link_up=0, if_rst=1, change_pulse=0, state_o=DOWN; counters 0.
//  - ib_hold {link,speed,duplex} registered on ib_valid; reset {0,2'b10,1}. Candidate cand =
//    cfg_auto ? ib_hold : {1,cfg_speed,cfg_duplex}. Candidate speed 11 treated as link=0.
//  - Applied status app = {link_up,speed,duplex}. One counter (width from max parameter) shared by states.
//  - States (state_o): DOWN=0, QUAL=1, DRAIN=2, SWRST=3, UP=4.
//  - DOWN: if_rst=1, link_up=0. cand.link=1 -> QUAL, latch cand into tgt, cnt=1.
//  - QUAL: if cand==tgt cnt++ else tgt<=cand, cnt=1. cand.link=0 -> DOWN (if entered from DOWN) or
//    back to UP (if entered from UP, app unchanged). cnt==STABLE_CYCLES with cand==tgt -> DRAIN if
//    entered from UP, else SWRST. Entry origin kept in a 1-bit flag.
//  - UP: if_rst=0, link_up=1. cand.link=0 -> link_up=0 next cycle, DRAIN (target = down). cand differs in
//    speed/duplex -> QUAL (link_up stays 1 during QUAL).
//  - DRAIN: link_up=0, if_rst=0. cnt counts consecutive idle cycles (reset on mac_tx_busy=1); a separate
//    timeout counter runs from entry. idle==IFG_CYCLES or timeout==DRAIN_TIMEOUT -> SWRST (target
//    link=1) or DOWN (target link=0).
//  - SWRST: speed/duplex <= tgt on entry cycle; if_rst=1 for exactly RST_CYCLES cycles -> UP;
//    change_pulse=1 on the first UP cycle.
//  - Latency from DOWN: cand stable from cycle 0 -> link_up=1 and change_pulse at cycle
//    STABLE_CYCLES+RST_CYCLES+1; speed updates at cycle STABLE_CYCLES+1.
//  - speed/duplex never change outside SWRST entry; speed never changes while if_rst=0.
//  - cfg_auto toggled mid-operation: treated as a candidate change (normal qualify path).
//  - rst asserted in any state: immediate return to reset values, in-progress switch abandoned.
//  - ib_valid and a state transition in the same cycle: FSM uses the registered ib_hold (1-cycle lag).
// STRUCTURE
//  - Shared package rgmii_pkg: SPEED_10/100/1000 localparams, state encoding constants, status struct width.
//  - One sub-module: rgmii_status_qualifier (tgt latch + stability counter, outputs stable/changed);
//    FSM, drain/timeout and reset timing in top. Target ~200 lines.
// TESTING (STABLE=8, IFG=12, TIMEOUT=64, RST=4)
//  1 rst release, cfg_auto=1, ib {1,01,1} valid at cycle 0 -> speed=01 at cycle 10, link_up=1 and
//    change_pulse at cycle 14 (ib_hold lag included), if_rst low same cycle.
//  2 in UP 1G, ib glitches to 100M for 5 cycles then back -> no change; speed stays 10, no pulse.
//  3 UP 1G, ib -> 100M stable, mac_tx_busy high 30 more cycles -> speed changes only after 12 idle
//    cycles following busy drop; if_rst high 4 cycles; change_pulse once.
//  4 UP, mac_tx_busy stuck 1, ib speed change -> SWRST forced after 64 DRAIN cycles.
//  5 UP, ib_link=0 -> link_up=0 next cycle, DOWN after drain, if_rst=1, speed unchanged.
//  6 cfg_auto=0 cfg_speed=00; rst pulsed mid-SWRST -> outputs to reset values, then 10M link_up=1.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII link/speed sequencer: speed codes, FSM state
// encoding and the packed link status word.
package rgmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  typedef enum logic [2:0] {
    ST_DOWN  = 3'd0,
    ST_QUAL  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SWRST = 3'd3,
    ST_UP    = 3'd4
  } state_e;

  typedef struct packed {
    logic       link;
    logic [1:0] speed;
    logic       duplex;
  } status_t;

  localparam int STATUS_W = $bits(status_t);

  localparam status_t STATUS_RST = '{link: 1'b0, speed: SPEED_1000, duplex: 1'b1};

  // The reserved speed code can never be applied, so it is reported as link down.
  function automatic status_t qualify_status(input status_t s);
    status_t r;
    r = s;
    if (!(s.speed inside {SPEED_10, SPEED_100, SPEED_1000})) begin
      r.link = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rgmii_status_qualifier.sv
// Holds the target status and counts how many consecutive cycles the candidate
// has matched it; stable_o fires once the candidate has held long enough.
module rgmii_status_qualifier
  import rgmii_pkg::*;
#(
  parameter int STABLE_CYCLES = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  status_t cand_i,
  input  logic    load_i,
  input  logic    en_i,
  output status_t tgt_o,
  output logic    stable_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  status_t             tgt_q, tgt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [STATUS_W-1:0] diff;
  logic                changed;

  assign diff     = cand_i ^ tgt_q;
  assign changed  = |diff;
  assign stable_o = en_i && !changed && (cnt_q == CW'(STABLE_CYCLES));
  assign tgt_o    = tgt_q;

  // Any disagreement restarts the count against the new candidate; the count
  // saturates so a long stay in qualification cannot wrap it.
  always_comb begin
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    if (load_i) begin
      tgt_d = cand_i;
      cnt_d = CW'(1);
    end else if (en_i) begin
      if (changed) begin
        tgt_d = cand_i;
        cnt_d = CW'(1);
      end else if (cnt_q != CW'(STABLE_CYCLES)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q <= STATUS_RST;
      cnt_q <= '0;
    end else begin
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgmii_link_speed_ctrl.sv
// Link/speed sequencer for rgmii_phy_if: qualifies the PHY (or forced) status and
// applies every change by draining MAC TX, resetting the interface and switching speed.
module rgmii_link_speed_ctrl
  import rgmii_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int IFG_CYCLES    = 12,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int RST_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_auto,
  input  logic [1:0] cfg_speed,
  input  logic       cfg_duplex,
  input  logic       ib_valid,
  input  logic       ib_link,
  input  logic [1:0] ib_speed,
  input  logic       ib_duplex,
  input  logic       mac_tx_busy,
  output logic [1:0] speed,
  output logic       duplex,
  output logic       link_up,
  output logic       if_rst,
  output logic       change_pulse,
  output logic [2:0] state_o
);

  localparam int CNT_MAX = (DRAIN_TIMEOUT > RST_CYCLES) ? DRAIN_TIMEOUT : RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  status_t       ib_hold_q, ib_hold_d;
  status_t       cand_raw, cand, tgt;
  state_e        state_q;
  logic          from_up_q;
  logic [CW-1:0] cnt_q, tmo_q;
  logic [1:0]    speed_q;
  logic          duplex_q, link_up_q, if_rst_q, pulse_q;
  logic          app_same, qual_load, qual_en, qual_stable, drain_done;

  always_comb begin
    ib_hold_d = ib_hold_q;
    if (ib_valid) begin
      ib_hold_d = '{link: ib_link, speed: ib_speed, duplex: ib_duplex};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ib_hold_q <= STATUS_RST;
    end else begin
      ib_hold_q <= ib_hold_d;
    end
  end

  assign cand_raw = cfg_auto ? ib_hold_q
                             : status_t'{link: 1'b1, speed: cfg_speed, duplex: cfg_duplex};
  assign cand     = qualify_status(cand_raw);
  assign app_same = (cand.speed == speed_q) && (cand.duplex == duplex_q);

  // A link loss in UP also loads the target, so DRAIN can pick its exit from tgt.link.
  assign qual_load = ((state_q == ST_DOWN) && cand.link) ||
                     ((state_q == ST_UP) && (!cand.link || !app_same));
  assign qual_en   = (state_q == ST_QUAL);

  assign drain_done = (!mac_tx_busy && (cnt_q == CW'(IFG_CYCLES - 1))) ||
                      (tmo_q == CW'(DRAIN_TIMEOUT - 1));

  rgmii_status_qualifier #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_qual (
    .clk     (clk),
    .rst     (rst),
    .cand_i  (cand),
    .load_i  (qual_load),
    .en_i    (qual_en),
    .tgt_o   (tgt),
    .stable_o(qual_stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DOWN;
      from_up_q <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      speed_q   <= SPEED_1000;
      duplex_q  <= 1'b1;
      link_up_q <= 1'b0;
      if_rst_q  <= 1'b1;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_DOWN: begin
          link_up_q <= 1'b0;
          if_rst_q  <= 1'b1;
          if (cand.link) begin
            state_q   <= ST_QUAL;
            from_up_q <= 1'b0;
          end
        end
        // Coming from UP the interface keeps running until the change is proven.
        ST_QUAL: begin
          if (!cand.link) begin
            state_q <= from_up_q ? ST_UP : ST_DOWN;
          end else if (from_up_q && app_same) begin
            state_q <= ST_UP;
          end else if (qual_stable) begin
            if (from_up_q) begin
              state_q   <= ST_DRAIN;
              link_up_q <= 1'b0;
              cnt_q     <= '0;
              tmo_q     <= '0;
            end else begin
              state_q  <= ST_SWRST;
              speed_q  <= tgt.speed;
              duplex_q <= tgt.duplex;
              if_rst_q <= 1'b1;
              cnt_q    <= CW'(1);
            end
          end
        end
        ST_UP: begin
          if (!cand.link) begin
            state_q   <= ST_DRAIN;
            link_up_q <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
          end else if (!app_same) begin
            state_q   <= ST_QUAL;
            from_up_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          cnt_q <= mac_tx_busy ? '0 : cnt_q + CW'(1);
          tmo_q <= tmo_q + CW'(1);
          if (drain_done) begin
            if_rst_q <= 1'b1;
            if (tgt.link) begin
              state_q  <= ST_SWRST;
              speed_q  <= tgt.speed;
              duplex_q <= tgt.duplex;
              cnt_q    <= CW'(1);
            end else begin
              state_q <= ST_DOWN;
            end
          end
        end
        ST_SWRST: begin
          if (cnt_q == CW'(RST_CYCLES)) begin
            state_q   <= ST_UP;
            if_rst_q  <= 1'b0;
            link_up_q <= 1'b1;
            pulse_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q   <= ST_DOWN;
          link_up_q <= 1'b0;
          if_rst_q  <= 1'b1;
        end
      endcase
    end
  end

  assign speed        = speed_q;
  assign duplex       = duplex_q;
  assign link_up      = link_up_q;
  assign if_rst       = if_rst_q;
  assign change_pulse = pulse_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_rgmii_link_speed_ctrl.sv
// Directed bench for rgmii_link_speed_ctrl with STABLE=8, IFG=12, TIMEOUT=64, RST=4;
// cycle numbers in each scenario count from the cycle its first stimulus is applied.
module tb_rgmii_link_speed_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfgAuto, cfgDuplex, ibValid, ibLink, ibDuplex, macTxBusy;
  logic [1:0] cfgSpeed, ibSpeed;
  logic [1:0] speed;
  logic       duplex, linkUp, ifRst, changePulse;
  logic [2:0] stateO;

  int testsRun    = 0;
  int testsFailed = 0;
  int pulseCount  = 0;
  int pulseBase   = 0;
  int speedFaults = 0;
  logic [1:0] prevSpeed = 2'b10;

  rgmii_link_speed_ctrl #(
    .STABLE_CYCLES(8),
    .IFG_CYCLES   (12),
    .DRAIN_TIMEOUT(64),
    .RST_CYCLES   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_auto    (cfgAuto),
    .cfg_speed   (cfgSpeed),
    .cfg_duplex  (cfgDuplex),
    .ib_valid    (ibValid),
    .ib_link     (ibLink),
    .ib_speed    (ibSpeed),
    .ib_duplex   (ibDuplex),
    .mac_tx_busy (macTxBusy),
    .speed       (speed),
    .duplex      (duplex),
    .link_up     (linkUp),
    .if_rst      (ifRst),
    .change_pulse(changePulse),
    .state_o     (stateO)
  );

  always #5 clk = ~clk;

  // Speed may only move while the interface is held in reset.
  always @(negedge clk) begin
    if (changePulse === 1'b1) pulseCount++;
    if (speed !== prevSpeed && ifRst !== 1'b1) speedFaults++;
    prevSpeed = speed;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic link, input logic [1:0] spd, input logic dup);
    ibLink   = link;
    ibSpeed  = spd;
    ibDuplex = dup;
    ibValid  = 1'b1;
    waitCycles(1);
    ibValid  = 1'b0;
  endtask

  initial begin
    cfgAuto   = 1'b1;
    cfgSpeed  = 2'b00;
    cfgDuplex = 1'b1;
    ibValid   = 1'b0;
    ibLink    = 1'b0;
    ibSpeed   = 2'b10;
    ibDuplex  = 1'b1;
    macTxBusy = 1'b0;
    #1 rst = 1'b1;
    waitCycles(3);
    checkOutput("rstSpeed", 32'(speed), 32'h2);
    checkOutput("rstDuplex", 32'(duplex), 32'h1);
    checkOutput("rstLinkUp", 32'(linkUp), 32'h0);
    checkOutput("rstIfRst", 32'(ifRst), 32'h1);
    checkOutput("rstPulse", 32'(changePulse), 32'h0);
    checkOutput("rstState", 32'(stateO), 32'h0);

    // Bring-up from DOWN at 100M full duplex
    rst = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b1);
    waitCycles(8);
    checkOutput("upQualState", 32'(stateO), 32'h1);
    checkOutput("upSpeedBefore", 32'(speed), 32'h2);
    waitCycles(1);
    checkOutput("upSpeed10", 32'(speed), 32'h1);
    checkOutput("upSwrstState", 32'(stateO), 32'h3);
    checkOutput("upIfRst10", 32'(ifRst), 32'h1);
    waitCycles(3);
    checkOutput("upLinkUp13", 32'(linkUp), 32'h0);
    checkOutput("upIfRst13", 32'(ifRst), 32'h1);
    waitCycles(1);
    checkOutput("upLinkUp14", 32'(linkUp), 32'h1);
    checkOutput("upPulse14", 32'(changePulse), 32'h1);
    checkOutput("upIfRst14", 32'(ifRst), 32'h0);
    checkOutput("upState14", 32'(stateO), 32'h4);
    waitCycles(1);
    checkOutput("upPulse15", 32'(changePulse), 32'h0);

    // Idle switch 100M -> 1G
    pulseBase = pulseCount;
    applyStimulus(1'b1, 2'b10, 1'b1);
    waitCycles(8);
    checkOutput("to1gQualState", 32'(stateO), 32'h1);
    checkOutput("to1gQualLinkUp", 32'(linkUp), 32'h1);
    waitCycles(1);
    checkOutput("to1gDrainState", 32'(stateO), 32'h2);
    checkOutput("to1gDrainLinkUp", 32'(linkUp), 32'h0);
    checkOutput("to1gDrainIfRst", 32'(ifRst), 32'h0);
    waitCycles(11);
    checkOutput("to1gDrainEnd", 32'(stateO), 32'h2);
    checkOutput("to1gSpeedHeld", 32'(speed), 32'h1);
    waitCycles(1);
    checkOutput("to1gSwrstState", 32'(stateO), 32'h3);
    checkOutput("to1gSpeed", 32'(speed), 32'h2);
    checkOutput("to1gIfRst", 32'(ifRst), 32'h1);
    waitCycles(4);
    checkOutput("to1gUpState", 32'(stateO), 32'h4);
    checkOutput("to1gLinkUp", 32'(linkUp), 32'h1);
    waitCycles(1);
    checkOutput("to1gPulses", 32'(pulseCount - pulseBase), 32'h1);

    // Five-cycle glitch to 100M must not disturb the 1G link
    pulseBase = pulseCount;
    applyStimulus(1'b1, 2'b01, 1'b1);
    waitCycles(2);
    checkOutput("glitchQualState", 32'(stateO), 32'h1);
    checkOutput("glitchQualLinkUp", 32'(linkUp), 32'h1);
    waitCycles(2);
    applyStimulus(1'b1, 2'b10, 1'b1);
    waitCycles(20);
    checkOutput("glitchState", 32'(stateO), 32'h4);
    checkOutput("glitchSpeed", 32'(speed), 32'h2);
    checkOutput("glitchLinkUp", 32'(linkUp), 32'h1);
    checkOutput("glitchPulses", 32'(pulseCount - pulseBase), 32'h0);

    // 1G -> 100M while MAC stays busy until cycle 30
    pulseBase = pulseCount;
    macTxBusy = 1'b1;
    applyStimulus(1'b1, 2'b01, 1'b1);
    waitCycles(19);
    checkOutput("busyDrainState", 32'(stateO), 32'h2);
    checkOutput("busyDrainLinkUp", 32'(linkUp), 32'h0);
    waitCycles(10);
    macTxBusy = 1'b0;
    waitCycles(11);
    checkOutput("busyDrainEnd", 32'(stateO), 32'h2);
    checkOutput("busySpeedHeld", 32'(speed), 32'h2);
    waitCycles(1);
    checkOutput("busySpeed", 32'(speed), 32'h1);
    checkOutput("busyIfRst42", 32'(ifRst), 32'h1);
    waitCycles(3);
    checkOutput("busyIfRst45", 32'(ifRst), 32'h1);
    waitCycles(1);
    checkOutput("busyIfRst46", 32'(ifRst), 32'h0);
    checkOutput("busyLinkUp46", 32'(linkUp), 32'h1);
    waitCycles(1);
    checkOutput("busyPulses", 32'(pulseCount - pulseBase), 32'h1);

    // MAC stuck busy: drain timeout forces the switch back to 1G
    macTxBusy = 1'b1;
    applyStimulus(1'b1, 2'b10, 1'b1);
    waitCycles(72);
    checkOutput("tmoDrainLast", 32'(stateO), 32'h2);
    checkOutput("tmoSpeedHeld", 32'(speed), 32'h1);
    waitCycles(1);
    checkOutput("tmoSwrstState", 32'(stateO), 32'h3);
    checkOutput("tmoSpeed", 32'(speed), 32'h2);
    macTxBusy = 1'b0;
    waitCycles(4);
    checkOutput("tmoUpState", 32'(stateO), 32'h4);
    checkOutput("tmoLinkUp", 32'(linkUp), 32'h1);

    // Link loss: link_up drops at once, DOWN after the drain
    applyStimulus(1'b0, 2'b10, 1'b1);
    checkOutput("lossLinkUp1", 32'(linkUp), 32'h1);
    waitCycles(1);
    checkOutput("lossLinkUp2", 32'(linkUp), 32'h0);
    checkOutput("lossDrainState", 32'(stateO), 32'h2);
    checkOutput("lossDrainIfRst", 32'(ifRst), 32'h0);
    waitCycles(11);
    checkOutput("lossDrainEnd", 32'(stateO), 32'h2);
    waitCycles(1);
    checkOutput("lossDownState", 32'(stateO), 32'h0);
    checkOutput("lossIfRst", 32'(ifRst), 32'h1);
    checkOutput("lossSpeed", 32'(speed), 32'h2);

    // Forced 10M half duplex, reset pulsed in the middle of the switch
    cfgAuto   = 1'b0;
    cfgSpeed  = 2'b00;
    cfgDuplex = 1'b0;
    waitCycles(9);
    checkOutput("forceSpeed9", 32'(speed), 32'h0);
    checkOutput("forceDuplex9", 32'(duplex), 32'h0);
    checkOutput("forceSwrst9", 32'(stateO), 32'h3);
    waitCycles(1);
    rst = 1'b1;
    #1;
    checkOutput("midRstSpeed", 32'(speed), 32'h2);
    checkOutput("midRstDuplex", 32'(duplex), 32'h1);
    checkOutput("midRstState", 32'(stateO), 32'h0);
    checkOutput("midRstIfRst", 32'(ifRst), 32'h1);
    checkOutput("midRstLinkUp", 32'(linkUp), 32'h0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(9);
    checkOutput("reforceSpeed", 32'(speed), 32'h0);
    waitCycles(4);
    checkOutput("reforceLinkUp", 32'(linkUp), 32'h1);
    checkOutput("reforcePulse", 32'(changePulse), 32'h1);
    checkOutput("reforceDuplex", 32'(duplex), 32'h0);
    checkOutput("reforceState", 32'(stateO), 32'h4);

    checkOutput("speedOnlyInReset", 32'(speedFaults), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
